// File: rtl/fp_arb_sched_if.sv
// ---------------------------------------------------------------------------
// fp_arb_sched_if
// Purpose : bundles the requester, FP-execution-unit and response signals of
//           the two-requester FP arbiter/scheduler into one interface.
// Signals : req_valid/req_ready       per-requester request handshake
//           req_data1..3/op/fmt/rm    per-requester operands and controls
//           fp_data1..3/op/fmt/rm     registered operands to the FP unit
//           fp_enable                 one-cycle start pulse to the FP unit
//           fp_result/fp_flags/ready  completion from the FP unit
//           rsp_valid/rsp_ready       per-requester response handshake
//           rsp_result/flags/err      shared response buffer
// Modports: slave  - the arbiter itself
//           master - the environment (requesters + FP unit + response sinks)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface fp_arb_sched_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_data1;
    logic [1:0][63:0] req_data2;
    logic [1:0][63:0] req_data3;
    logic [1:0][19:0] req_op;
    logic [1:0][1:0]  req_fmt;
    logic [1:0][2:0]  req_rm;

    logic [63:0]      fp_data1;
    logic [63:0]      fp_data2;
    logic [63:0]      fp_data3;
    logic [19:0]      fp_op;
    logic [1:0]       fp_fmt;
    logic [2:0]       fp_rm;
    logic             fp_enable;
    logic [63:0]      fp_result;
    logic [4:0]       fp_flags;
    logic             fp_ready;

    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [63:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_data1, req_data2, req_data3, req_op, req_fmt, req_rm,
        output req_ready,
        output fp_data1, fp_data2, fp_data3, fp_op, fp_fmt, fp_rm, fp_enable,
        input  fp_result, fp_flags, fp_ready,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_data1, req_data2, req_data3, req_op, req_fmt, req_rm,
        input  req_ready,
        input  fp_data1, fp_data2, fp_data3, fp_op, fp_fmt, fp_rm, fp_enable,
        output fp_result, fp_flags, fp_ready,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/fp_arb_sched.sv
// ---------------------------------------------------------------------------
// fp_arb_sched
// Purpose : shares one FP execution unit between two requesters. Round-robin
//           arbitration, one outstanding operation, a watchdog that returns an
//           error response if the FP unit never completes, and a buffered
//           response held until the granted requester accepts it.
// Ports   : clock  - single rising-edge clock
//           reset  - synchronous active-low reset
//           bus    - fp_arb_sched_if.slave (request, FP unit, response sides)
// Params  : WDOG   - cycles allowed in WAIT before the watchdog fires (1..65535)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_arb_sched #(
    parameter int WDOG = 1023
) (
    input  logic               clock,
    input  logic               reset,
    fp_arb_sched_if.slave      bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The counter is compared before its increment, so the limit is WDOG-1:
    // the cycle whose increment would make it reach WDOG is the timeout cycle.
    localparam logic [15:0] WDOG_M1 = 16'(WDOG - 1);

    logic [1:0]  r_state;
    logic        r_rr;
    logic        r_grant;
    logic [15:0] r_wdog;
    logic [63:0] r_fpData1;
    logic [63:0] r_fpData2;
    logic [63:0] r_fpData3;
    logic [19:0] r_fpOp;
    logic [1:0]  r_fpFmt;
    logic [2:0]  r_fpRm;
    logic [63:0] r_rspResult;
    logic [4:0]  r_rspFlags;
    logic        r_rspErr;

    logic        w_grant;
    logic        w_idleOpen;
    logic        w_transfer;
    logic        w_wdogHit;

    // Arbitration: with both valid the rr pointer decides, otherwise the lone
    // valid requester wins. The ready path is gated by reset so nothing can be
    // accepted while reset is held.
    always_comb begin
        w_grant       = (&bus.req_valid) ? r_rr : ~bus.req_valid[0];
        w_idleOpen    = reset && (r_state == S_IDLE);
        bus.req_ready = 2'b00;
        bus.req_ready[0] = w_idleOpen && bus.req_valid[0] && !w_grant;
        bus.req_ready[1] = w_idleOpen && bus.req_valid[1] &&  w_grant;
        w_transfer    = |bus.req_ready;
        w_wdogHit     = (r_wdog >= WDOG_M1);
    end

    // Output decode: the start pulse and response valid come straight from
    // the state register, so they are glitch-free and exactly one state wide.
    always_comb begin
        bus.fp_data1   = r_fpData1;
        bus.fp_data2   = r_fpData2;
        bus.fp_data3   = r_fpData3;
        bus.fp_op      = r_fpOp;
        bus.fp_fmt     = r_fpFmt;
        bus.fp_rm      = r_fpRm;
        bus.fp_enable  = (r_state == S_ISSUE);
        bus.rsp_valid  = 2'b00;
        if (r_state == S_RESP) begin
            bus.rsp_valid[r_grant] = 1'b1;
        end
        bus.rsp_result = r_rspResult;
        bus.rsp_flags  = r_rspFlags;
        bus.rsp_err    = r_rspErr;
    end

    // Main sequencer. fp_ready is only looked at in ISSUE/WAIT, so a late
    // completion after reset or during RESP is silently dropped. In WAIT a
    // real completion beats the watchdog when both happen in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr        <= 1'b0;
            r_grant     <= 1'b0;
            r_wdog      <= 16'd0;
            r_fpData1   <= 64'd0;
            r_fpData2   <= 64'd0;
            r_fpData3   <= 64'd0;
            r_fpOp      <= 20'd0;
            r_fpFmt     <= 2'd0;
            r_fpRm      <= 3'd0;
            r_rspResult <= 64'd0;
            r_rspFlags  <= 5'd0;
            r_rspErr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_transfer) begin
                        r_fpData1 <= bus.req_data1[w_grant];
                        r_fpData2 <= bus.req_data2[w_grant];
                        r_fpData3 <= bus.req_data3[w_grant];
                        r_fpOp    <= bus.req_op[w_grant];
                        r_fpFmt   <= bus.req_fmt[w_grant];
                        r_fpRm    <= bus.req_rm[w_grant];
                        r_grant   <= w_grant;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.fp_ready) begin
                        r_rspResult <= bus.fp_result;
                        r_rspFlags  <= bus.fp_flags;
                        r_rspErr    <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog  <= 16'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.fp_ready) begin
                        r_rspResult <= bus.fp_result;
                        r_rspFlags  <= bus.fp_flags;
                        r_rspErr    <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        if (r_wdog != 16'hFFFF) begin
                            r_wdog <= r_wdog + 16'd1;
                        end
                        if (w_wdogHit) begin
                            r_rspResult <= 64'd0;
                            r_rspFlags  <= 5'd0;
                            r_rspErr    <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[r_grant]) begin
                        r_rr    <= ~r_grant;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_arb_sched.sv
`timescale 1ns/1ps
module tb_fp_arb_sched;

    localparam int WDOG  = 8;
    localparam int NEVER = 1000;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Reference state: which requester wins when both ask. Reset clears it,
    // every accepted response hands priority to the other requester.
    bit   rrModel;

    fp_arb_sched_if bus();

    fp_arb_sched #(.WDOG(WDOG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic randomizeRequests();
        for (int i = 0; i < 2; i++) begin
            bus.req_data1[i] = {$urandom, $urandom};
            bus.req_data2[i] = {$urandom, $urandom};
            bus.req_data3[i] = {$urandom, $urandom};
            bus.req_op[i]    = 20'($urandom);
            bus.req_fmt[i]   = 2'($urandom);
            bus.req_rm[i]    = 3'($urandom);
        end
    endtask

    // One complete operation. Called half a cycle before an edge with the
    // DUT idle; returns in the same position. d = cycles after fp_enable at
    // which fp_ready is pulsed (d > WDOG means the FP unit never answers),
    // hold = cycles the granted requester stalls the response.
    task automatic applyStimulus(input logic [1:0] mask, input int d, input int hold,
                                 input bit fixed, input logic [63:0] fixD1,
                                 input logic [63:0] fixRes, input logic [4:0] fixFl);
        logic [63:0] d1, d2, d3, res, expRes;
        logic [24:0] ctrl;
        logic [4:0]  fl, expFl;
        logic [1:0]  expValid;
        logic        expErr;
        int          g, k, expK, enBad, rdyBad, holdBad;
        bit          got;

        randomizeRequests();
        if (fixed) begin
            bus.req_data1[0] = fixD1;
            bus.req_data1[1] = fixD1;
        end
        bus.req_valid = mask;
        bus.rsp_ready = 2'b00;
        bus.fp_ready  = 1'b0;
        g        = (mask == 2'b11) ? int'(rrModel) : (mask[0] ? 0 : 1);
        expValid = 2'(1 << g);
        #1;
        checkOutput("req_ready_grant", 64'(bus.req_ready), 64'(expValid));

        d1   = bus.req_data1[g];
        d2   = bus.req_data2[g];
        d3   = bus.req_data3[g];
        ctrl = {bus.req_op[g], bus.req_fmt[g], bus.req_rm[g]};
        res  = fixed ? fixRes : {$urandom, $urandom};
        fl   = fixed ? fixFl : 5'($urandom);

        // Operation outcome from the completion/timeout rules
        expK   = (d <= WDOG) ? d + 1 : WDOG + 1;
        expRes = (d <= WDOG) ? res : 64'd0;
        expFl  = (d <= WDOG) ? fl : 5'd0;
        expErr = (d <= WDOG) ? 1'b0 : 1'b1;

        @(negedge clock); #1;
        checkOutput("fp_enable_issue", 64'(bus.fp_enable), 64'd1);
        checkOutput("fp_data1", bus.fp_data1, d1);
        checkOutput("fp_data2", bus.fp_data2, d2);
        checkOutput("fp_data3", bus.fp_data3, d3);
        checkOutput("fp_ctrl", 64'({bus.fp_op, bus.fp_fmt, bus.fp_rm}), 64'(ctrl));

        got = 0; k = NEVER; enBad = 0; rdyBad = 0;
        for (int j = 0; j <= WDOG + 4 && !got; j++) begin
            if (j > 0) begin
                @(negedge clock); #1;
            end
            if (bus.rsp_valid != 2'b00) begin
                got = 1;
                k   = j;
            end else begin
                if (j > 0 && bus.fp_enable !== 1'b0) enBad++;
                if (bus.req_ready !== 2'b00) rdyBad++;
                bus.fp_ready  = (j == d);
                bus.fp_result = (j == d) ? res : {$urandom, $urandom};
                bus.fp_flags  = (j == d) ? fl : 5'($urandom);
                bus.req_valid = 2'($urandom);
            end
        end
        checkOutput("rsp_latency", 64'(k), 64'(expK));
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(expValid));
        checkOutput("rsp_result", bus.rsp_result, expRes);
        checkOutput("rsp_flags", 64'(bus.rsp_flags), 64'(expFl));
        checkOutput("rsp_err", 64'(bus.rsp_err), 64'(expErr));
        checkOutput("fp_data1_hold", bus.fp_data1, d1);

        holdBad = 0;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = ~expValid;
            bus.req_valid = 2'b11;
            bus.fp_ready  = 1'($urandom);
            bus.fp_result = {$urandom, $urandom};
            bus.fp_flags  = 5'($urandom);
            @(negedge clock); #1;
            if (bus.rsp_valid !== expValid || bus.rsp_result !== expRes ||
                bus.rsp_flags !== expFl || bus.rsp_err !== expErr) holdBad++;
            if (bus.req_ready !== 2'b00 || bus.fp_enable !== 1'b0) holdBad++;
        end
        if (hold > 0) checkOutput("rsp_hold_stable", 64'(holdBad), 64'd0);

        bus.rsp_ready = expValid | (2'($urandom) & ~expValid);
        bus.req_valid = 2'b00;
        bus.fp_ready  = 1'($urandom);
        @(negedge clock); #1;
        rrModel = (g == 0);
        checkOutput("rsp_released", 64'(bus.rsp_valid), 64'd0);
        checkOutput("fp_enable_single", 64'(enBad), 64'd0);
        checkOutput("req_ready_busy", 64'(rdyBad), 64'd0);
        bus.rsp_ready = 2'b00;
        bus.fp_ready  = 1'b0;
    endtask

    // Overall time bound in case anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int stale;
        reset         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.fp_ready  = 1'b0;
        bus.fp_result = 64'd0;
        bus.fp_flags  = 5'd0;
        randomizeRequests();
        rrModel = 1'b0;

        // Reset state, with both requesters asking during reset
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("reset_fp_enable", 64'(bus.fp_enable), 64'd0);
        checkOutput("reset_fp_data1", bus.fp_data1, 64'd0);
        checkOutput("reset_fp_op", 64'(bus.fp_op), 64'd0);
        checkOutput("reset_rsp_result", bus.rsp_result, 64'd0);
        checkOutput("reset_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        checkOutput("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        bus.req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clock); #1;

        // Both valid, fast completion: grants alternate starting with 0
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1, 0, 1'b0, 64'd0, 64'd0, 5'd0);

        // Requester 1 alone with a known operand/result
        applyStimulus(2'b10, 1, 0, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 5'b00001);

        // Watchdog timeout and completion exactly at the limit
        applyStimulus(2'b11, NEVER, 1, 1'b0, 64'd0, 64'd0, 5'd0);
        applyStimulus(2'b01, WDOG, 0, 1'b0, 64'd0, 64'd0, 5'd0);

        // Long response stall with the other requester waiting
        applyStimulus(2'b01, 0, 20, 1'b0, 64'd0, 64'd0, 5'd0);

        // Give requester 1 priority, then reset in WAIT
        applyStimulus(2'b01, 0, 0, 1'b0, 64'd0, 64'd0, 5'd0);
        bus.req_valid = 2'b10;
        @(negedge clock); #1;
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clock);
        #1;
        reset         = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        checkOutput("reset_wait_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clock); #1;
        reset         = 1'b1;
        rrModel       = 1'b0;
        bus.req_valid = 2'b00;
        bus.fp_ready  = 1'b1;
        bus.fp_result = {$urandom, $urandom};
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            if (bus.rsp_valid !== 2'b00 || bus.fp_enable !== 1'b0) stale++;
        end
        checkOutput("reset_wait_no_rsp", 64'(stale), 64'd0);
        bus.fp_ready = 1'b0;
        applyStimulus(2'b11, 0, 0, 1'b0, 64'd0, 64'd0, 5'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [1:0] mask;
            int d;
            mask = 2'($urandom_range(1, 3));
            d    = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, WDOG + 2));
            applyStimulus(mask, d, int'($urandom_range(0, 3)), 1'b0, 64'd0, 64'd0, 5'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
